// File: rtl/hazard_pkg.sv
// Shared types and select encodings for the hazard/forwarding unit.
package hazard_pkg;

    localparam int REG_W_DEF = 5;
    localparam int SEL_RF    = 0;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

    function automatic int sel_stg(input int k);
        return k + 1;
    endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side bundle of the hazard/forwarding unit: DX/FD/stage inputs and mux/stall controls.
interface hazard_forward_unit_if #(
    parameter int REG_W          = 5,
    parameter int NUM_FWD_STAGES = 2,
    parameter int CNT_W          = 32,
    parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
);
    logic [REG_W-1:0]                fd_rs;
    logic [REG_W-1:0]                fd_rt;
    logic                            fd_uses_rs;
    logic                            fd_uses_rt;
    logic [REG_W-1:0]                dx_rs;
    logic [REG_W-1:0]                dx_rt;
    logic                            dx_uses_rs;
    logic                            dx_uses_rt;
    logic [REG_W-1:0]                dx_rd;
    logic                            dx_rwe;
    logic                            dx_is_load;
    logic                            dx_md_start;
    logic [NUM_FWD_STAGES*REG_W-1:0] stg_rd;
    logic [NUM_FWD_STAGES-1:0]       stg_rwe;
    logic                            xm_is_store;
    logic [REG_W-1:0]                xm_rt;
    logic [SEL_W-1:0]                sel_a;
    logic [SEL_W-1:0]                sel_b;
    logic                            sel_mem_data;
    logic                            stall_pc;
    logic                            stall_fd;
    logic                            stall_dx;
    logic                            bubble_dx;
    logic                            md_busy;
    logic                            md_done;
    logic [CNT_W-1:0]                stall_count;

    modport master (
        output fd_rs, fd_rt, fd_uses_rs, fd_uses_rt,
        output dx_rs, dx_rt, dx_uses_rs, dx_uses_rt, dx_rd, dx_rwe, dx_is_load, dx_md_start,
        output stg_rd, stg_rwe, xm_is_store, xm_rt,
        input  sel_a, sel_b, sel_mem_data, stall_pc, stall_fd, stall_dx, bubble_dx,
        input  md_busy, md_done, stall_count
    );

    modport slave (
        input  fd_rs, fd_rt, fd_uses_rs, fd_uses_rt,
        input  dx_rs, dx_rt, dx_uses_rs, dx_uses_rt, dx_rd, dx_rwe, dx_is_load, dx_md_start,
        input  stg_rd, stg_rwe, xm_is_store, xm_rt,
        output sel_a, sel_b, sel_mem_data, stall_pc, stall_fd, stall_dx, bubble_dx,
        output md_busy, md_done, stall_count
    );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// Priority encoder choosing the youngest forwarding stage whose destination matches a source register.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_W          = REG_W_DEF,
    parameter int NUM_FWD_STAGES = 2,
    parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic [REG_W-1:0]                src,
    input  logic                            uses,
    input  logic [NUM_FWD_STAGES*REG_W-1:0] stg_rd,
    input  logic [NUM_FWD_STAGES-1:0]       stg_rwe,
    output logic [SEL_W-1:0]                sel
);

    // Scan oldest to youngest so a younger match overwrites an older one.
    always_comb begin
        sel = SEL_W'(SEL_RF);
        for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
            if (uses && (src != {REG_W{1'b0}}) && stg_rwe[k] &&
                (stg_rd[k*REG_W +: REG_W] == src)) begin
                sel = SEL_W'(sel_stg(k));
            end else begin
                sel = sel;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding, load-use bubble insertion and mult/div front-end freeze for the DX stage.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_W          = REG_W_DEF,
    parameter int NUM_FWD_STAGES = 2,
    parameter int MD_LATENCY     = 32,
    parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1),
    parameter int CNT_W          = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    hazard_forward_unit_if.slave bus
);

    localparam int              MD_CW   = $clog2(MD_LATENCY);
    localparam logic [MD_CW-1:0] MD_LOAD = MD_CW'(MD_LATENCY - 1);

    md_state_t        state_r;
    md_state_t        state_next_s;
    logic [MD_CW-1:0] md_cnt_r;
    logic [MD_CW-1:0] md_cnt_next_s;
    logic [CNT_W-1:0] stall_count_r;
    logic             md_busy_s;
    logic             md_done_s;
    logic             luse_s;
    logic             luse_eff_s;
    logic             stall_front_s;
    logic             sel_mem_data_s;

    fwd_select #(.REG_W(REG_W), .NUM_FWD_STAGES(NUM_FWD_STAGES), .SEL_W(SEL_W)) u_sel_a (
        .src     (bus.dx_rs),
        .uses    (bus.dx_uses_rs),
        .stg_rd  (bus.stg_rd),
        .stg_rwe (bus.stg_rwe),
        .sel     (bus.sel_a)
    );

    fwd_select #(.REG_W(REG_W), .NUM_FWD_STAGES(NUM_FWD_STAGES), .SEL_W(SEL_W)) u_sel_b (
        .src     (bus.dx_rt),
        .uses    (bus.dx_uses_rt),
        .stg_rd  (bus.stg_rd),
        .stg_rwe (bus.stg_rwe),
        .sel     (bus.sel_b)
    );

    // Store data comes from the MW latch, which only exists with two or more stages.
    if (NUM_FWD_STAGES >= 2) begin : g_mem_fwd
        assign sel_mem_data_s = bus.xm_is_store && bus.stg_rwe[1] &&
                                (bus.stg_rd[REG_W +: REG_W] == bus.xm_rt) &&
                                (bus.xm_rt != {REG_W{1'b0}});
    end else begin : g_no_mem_fwd
        assign sel_mem_data_s = 1'b0;
    end

    assign luse_s = bus.dx_is_load && bus.dx_rwe && (bus.dx_rd != {REG_W{1'b0}}) &&
                    ((bus.fd_uses_rs && (bus.fd_rs == bus.dx_rd)) ||
                     (bus.fd_uses_rt && (bus.fd_rt == bus.dx_rd)));

    // A load-use seen alongside a mult/div start is absorbed by the md freeze and re-checked after it.
    assign luse_eff_s    = luse_s && (state_r == MD_IDLE) && !bus.dx_md_start;
    assign stall_front_s = md_busy_s || luse_eff_s;

    // Mult/div FSM next-state and status decode.
    always_comb begin
        state_next_s  = state_r;
        md_cnt_next_s = md_cnt_r;
        md_busy_s     = 1'b0;
        md_done_s     = 1'b0;
        case (state_r)
            MD_IDLE: begin
                if (bus.dx_md_start) begin
                    state_next_s  = MD_RUN;
                    md_cnt_next_s = MD_LOAD;
                end else begin
                    state_next_s  = MD_IDLE;
                end
            end
            MD_RUN: begin
                md_busy_s = 1'b1;
                if (md_cnt_r == {MD_CW{1'b0}}) begin
                    md_done_s    = 1'b1;
                    state_next_s = MD_IDLE;
                end else begin
                    md_cnt_next_s = md_cnt_r - MD_CW'(1);
                end
            end
            default: begin
                state_next_s  = MD_IDLE;
                md_cnt_next_s = {MD_CW{1'b0}};
            end
        endcase
    end

    // Mult/div state and latency counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= MD_IDLE;
            md_cnt_r <= {MD_CW{1'b0}};
        end else begin
            state_r  <= state_next_s;
            md_cnt_r <= md_cnt_next_s;
        end
    end

    // Saturating count of front-end stall cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (stall_front_s && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + CNT_W'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign bus.sel_mem_data = sel_mem_data_s;
    assign bus.stall_pc     = stall_front_s;
    assign bus.stall_fd     = stall_front_s;
    assign bus.stall_dx     = md_busy_s;
    assign bus.bubble_dx    = stall_front_s;
    assign bus.md_busy      = md_busy_s;
    assign bus.md_done      = md_done_s;
    assign bus.stall_count  = stall_count_r;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_forward_unit;

    localparam int RW  = 5;
    localparam int NS  = 3;
    localparam int LAT = 4;
    localparam int SAT_LAT = 9;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    hazard_forward_unit_if #(.REG_W(RW), .NUM_FWD_STAGES(NS), .CNT_W(32)) hif ();
    hazard_forward_unit_if #(.REG_W(RW), .NUM_FWD_STAGES(2),  .CNT_W(3))  sif ();

    hazard_forward_unit #(.REG_W(RW), .NUM_FWD_STAGES(NS), .MD_LATENCY(LAT), .CNT_W(32)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (hif)
    );

    hazard_forward_unit #(.REG_W(RW), .NUM_FWD_STAGES(2), .MD_LATENCY(SAT_LAT), .CNT_W(3)) u_sat (
        .clock (clock),
        .reset (reset),
        .bus   (sif)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state: remaining mult/div cycles and stall tally.
    int     md_left = 0;
    longint sc      = 0;
    logic [1:0] e_sel_a, e_sel_b;
    logic e_mem, e_stall, e_stall_dx, e_busy, e_done;

    function automatic int ref_sel(input logic [RW-1:0] src, input logic uses);
        for (int k = 0; k < NS; k++) begin
            if (uses && src != 5'd0 && hif.stg_rwe[k] && hif.stg_rd[k*RW +: RW] == src) return k + 1;
        end
        return 0;
    endfunction

    task automatic model_eval();
        logic luse;
        e_sel_a = 2'(ref_sel(hif.dx_rs, hif.dx_uses_rs));
        e_sel_b = 2'(ref_sel(hif.dx_rt, hif.dx_uses_rt));
        e_mem   = hif.xm_is_store && hif.stg_rwe[1] && hif.stg_rd[RW +: RW] == hif.xm_rt && hif.xm_rt != 5'd0;
        luse    = hif.dx_is_load && hif.dx_rwe && hif.dx_rd != 5'd0 &&
                  ((hif.fd_uses_rs && hif.fd_rs == hif.dx_rd) || (hif.fd_uses_rt && hif.fd_rt == hif.dx_rd));
        e_busy     = (md_left > 0);
        e_done     = (md_left == 1);
        e_stall    = e_busy || (luse && !hif.dx_md_start);
        e_stall_dx = e_busy;
    endtask

    task automatic model_step();
        if (e_stall && sc < 64'hFFFF_FFFF) sc = sc + 1;
        if (md_left > 0) md_left = md_left - 1;
        else if (hif.dx_md_start) md_left = LAT;
    endtask

    task automatic settle();
        @(negedge clock);
        model_eval();
    endtask

    task automatic advance();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        hif.fd_rs = 5'd0; hif.fd_rt = 5'd0; hif.fd_uses_rs = 1'b0; hif.fd_uses_rt = 1'b0;
        hif.dx_rs = 5'd0; hif.dx_rt = 5'd0; hif.dx_uses_rs = 1'b0; hif.dx_uses_rt = 1'b0;
        hif.dx_rd = 5'd0; hif.dx_rwe = 1'b0; hif.dx_is_load = 1'b0; hif.dx_md_start = 1'b0;
        hif.stg_rd = 15'd0; hif.stg_rwe = 3'd0; hif.xm_is_store = 1'b0; hif.xm_rt = 5'd0;
        sif.fd_rs = 5'd0; sif.fd_rt = 5'd0; sif.fd_uses_rs = 1'b0; sif.fd_uses_rt = 1'b0;
        sif.dx_rs = 5'd0; sif.dx_rt = 5'd0; sif.dx_uses_rs = 1'b0; sif.dx_uses_rt = 1'b0;
        sif.dx_rd = 5'd0; sif.dx_rwe = 1'b0; sif.dx_is_load = 1'b0; sif.dx_md_start = 1'b0;
        sif.stg_rd = 10'd0; sif.stg_rwe = 2'd0; sif.xm_is_store = 1'b0; sif.xm_rt = 5'd0;
    endtask

    task automatic test_reset();
        clear_inputs();
        #2;
        n_cmp++;
        if (hif.md_busy !== 1'b0 || hif.md_done !== 1'b0 || hif.stall_count !== 32'd0) begin
            n_err++; $display("FAIL reset_state: busy=%b done=%b count=%0d expected 0/0/0", hif.md_busy, hif.md_done, hif.stall_count);
        end
        n_cmp++;
        if (hif.stall_fd !== 1'b0 || hif.bubble_dx !== 1'b0 || hif.sel_a !== 2'd0 || sif.stall_count !== 3'd0) begin
            n_err++; $display("FAIL reset_outputs: stall_fd=%b bubble=%b sel_a=%0d sat_count=%0d expected 0", hif.stall_fd, hif.bubble_dx, hif.sel_a, sif.stall_count);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_forward();
        clear_inputs();
        hif.stg_rd[0 +: RW] = 5'd5; hif.stg_rd[RW +: RW] = 5'd5; hif.stg_rwe = 3'b011;
        hif.dx_rs = 5'd5; hif.dx_uses_rs = 1'b1;
        settle(); n_cmp++;
        if (hif.sel_a !== 2'd1) begin n_err++; $display("FAIL double_hazard_young: sel_a=%0d expected 1", hif.sel_a); end
        advance();
        hif.stg_rwe = 3'b010;
        settle(); n_cmp++;
        if (hif.sel_a !== 2'd2) begin n_err++; $display("FAIL double_hazard_mw: sel_a=%0d expected 2", hif.sel_a); end
        advance();
        hif.stg_rd[2*RW +: RW] = 5'd5; hif.stg_rwe = 3'b100;
        settle(); n_cmp++;
        if (hif.sel_a !== 2'd3) begin n_err++; $display("FAIL oldest_stage: sel_a=%0d expected 3", hif.sel_a); end
        advance();
        hif.dx_uses_rs = 1'b0;
        settle(); n_cmp++;
        if (hif.sel_a !== 2'd0) begin n_err++; $display("FAIL unused_rs: sel_a=%0d expected 0", hif.sel_a); end
        advance();
        clear_inputs();
        hif.dx_rt = 5'd0; hif.dx_uses_rt = 1'b1; hif.stg_rd[0 +: RW] = 5'd0; hif.stg_rwe = 3'b001;
        settle(); n_cmp++;
        if (hif.sel_b !== 2'd0) begin n_err++; $display("FAIL r0_guard: sel_b=%0d expected 0", hif.sel_b); end
        advance();
        hif.dx_rt = 5'd9; hif.stg_rd[0 +: RW] = 5'd9;
        settle(); n_cmp++;
        if (hif.sel_b !== 2'd1) begin n_err++; $display("FAIL sel_b_xm: sel_b=%0d expected 1", hif.sel_b); end
        advance();
        clear_inputs();
        hif.xm_is_store = 1'b1; hif.xm_rt = 5'd7; hif.stg_rd[RW +: RW] = 5'd7; hif.stg_rwe = 3'b010;
        settle(); n_cmp++;
        if (hif.sel_mem_data !== 1'b1) begin n_err++; $display("FAIL mem_fwd: sel_mem_data=%b expected 1", hif.sel_mem_data); end
        advance();
        hif.xm_rt = 5'd0; hif.stg_rd[RW +: RW] = 5'd0;
        settle(); n_cmp++;
        if (hif.sel_mem_data !== 1'b0) begin n_err++; $display("FAIL mem_fwd_r0: sel_mem_data=%b expected 0", hif.sel_mem_data); end
        advance();
        clear_inputs();
    endtask

    task automatic test_load_use();
        longint sc0;
        clear_inputs();
        hif.dx_is_load = 1'b1; hif.dx_rwe = 1'b1; hif.dx_rd = 5'd3; hif.fd_rs = 5'd3; hif.fd_uses_rs = 1'b1;
        settle(); sc0 = sc; n_cmp++;
        if (hif.stall_pc !== 1'b1 || hif.stall_fd !== 1'b1 || hif.bubble_dx !== 1'b1 || hif.stall_dx !== 1'b0) begin
            n_err++; $display("FAIL load_use_stall: pc=%b fd=%b bub=%b dx=%b expected 1/1/1/0", hif.stall_pc, hif.stall_fd, hif.bubble_dx, hif.stall_dx);
        end
        advance();
        clear_inputs();
        hif.stg_rd[0 +: RW] = 5'd3; hif.stg_rwe = 3'b001; hif.dx_rs = 5'd3; hif.dx_uses_rs = 1'b1;
        settle(); n_cmp++;
        if (hif.sel_a !== 2'd1 || hif.stall_fd !== 1'b0 || hif.bubble_dx !== 1'b0) begin
            n_err++; $display("FAIL load_use_resolve: sel_a=%0d stall=%b bub=%b expected 1/0/0", hif.sel_a, hif.stall_fd, hif.bubble_dx);
        end
        n_cmp++;
        if (hif.stall_count !== 32'(sc0 + 1)) begin n_err++; $display("FAIL load_use_count: count=%0d expected %0d", hif.stall_count, sc0 + 1); end
        advance();
        clear_inputs();
    endtask

    task automatic test_md();
        longint sc0;
        clear_inputs();
        hif.dx_md_start = 1'b1;
        hif.dx_is_load = 1'b1; hif.dx_rwe = 1'b1; hif.dx_rd = 5'd4; hif.fd_rt = 5'd4; hif.fd_uses_rt = 1'b1;
        settle(); sc0 = sc; n_cmp++;
        if (hif.md_busy !== 1'b0 || hif.stall_fd !== 1'b0) begin
            n_err++; $display("FAIL md_start_cycle: busy=%b stall=%b expected 0/0", hif.md_busy, hif.stall_fd);
        end
        advance();
        for (int i = 1; i <= LAT; i++) begin
            settle(); n_cmp++;
            if (hif.md_busy !== 1'b1 || hif.stall_dx !== 1'b1 || hif.stall_pc !== 1'b1 || hif.bubble_dx !== 1'b1 ||
                hif.md_done !== (i == LAT)) begin
                n_err++; $display("FAIL md_run_c%0d: busy=%b dx=%b pc=%b bub=%b done=%b expected 1/1/1/1/%b",
                                  i, hif.md_busy, hif.stall_dx, hif.stall_pc, hif.bubble_dx, hif.md_done, (i == LAT));
            end
            advance();
            hif.dx_md_start = (i == 1);
        end
        hif.dx_md_start = 1'b0;
        settle(); n_cmp++;
        if (hif.md_busy !== 1'b0 || hif.md_done !== 1'b0 || hif.stall_fd !== 1'b1 || hif.stall_dx !== 1'b0) begin
            n_err++; $display("FAIL md_deferred_luse: busy=%b done=%b stall_fd=%b stall_dx=%b expected 0/0/1/0", hif.md_busy, hif.md_done, hif.stall_fd, hif.stall_dx);
        end
        n_cmp++;
        if (hif.stall_count !== 32'(sc0 + LAT)) begin n_err++; $display("FAIL md_count: count=%0d expected %0d", hif.stall_count, sc0 + LAT); end
        advance();
        clear_inputs();
        settle(); advance();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        hif.dx_md_start = 1'b1;
        settle(); advance();
        hif.dx_md_start = 1'b0;
        settle(); advance();
        settle();
        #1 reset = 1'b0;
        #1;
        md_left = 0; sc = 0;
        n_cmp++;
        if (hif.md_busy !== 1'b0 || hif.stall_count !== 32'd0 || hif.stall_fd !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_md: busy=%b count=%0d stall=%b expected 0/0/0", hif.md_busy, hif.stall_count, hif.stall_fd);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 6; i++) begin
            settle(); n_cmp++;
            if (hif.md_busy !== 1'b0 || hif.md_done !== 1'b0 || hif.stall_count !== 32'd0) begin
                n_err++; $display("FAIL post_reset_idle: busy=%b done=%b count=%0d expected 0/0/0", hif.md_busy, hif.md_done, hif.stall_count);
            end
            advance();
        end
    endtask

    task automatic test_saturation();
        int sat_left = 0;
        int sat_n = 0;
        clear_inputs();
        sif.dx_md_start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            settle(); n_cmp++;
            if (sif.md_busy !== (sat_left > 0) || sif.stall_count !== 3'((sat_n > 7) ? 7 : sat_n)) begin
                n_err++; $display("FAIL saturation_c%0d: busy=%b count=%0d expected %b/%0d",
                                  i, sif.md_busy, sif.stall_count, (sat_left > 0), (sat_n > 7) ? 7 : sat_n);
            end
            if (sat_left > 0) begin sat_n++; sat_left--; end
            else if (sif.dx_md_start) sat_left = SAT_LAT;
            advance();
            sif.dx_md_start = 1'b0;
        end
        n_cmp++;
        if (sif.stall_count !== 3'd7) begin n_err++; $display("FAIL saturation_hold: count=%0d expected 7", sif.stall_count); end
    endtask

    task automatic test_random();
        logic [10:0] act, exp;
        for (int i = 0; i < 400; i++) begin
            hif.fd_rs = 5'($urandom_range(0, 3)); hif.fd_rt = 5'($urandom_range(0, 3));
            hif.fd_uses_rs = 1'($urandom); hif.fd_uses_rt = 1'($urandom);
            hif.dx_rs = 5'($urandom_range(0, 3)); hif.dx_rt = 5'($urandom_range(0, 3));
            hif.dx_uses_rs = 1'($urandom); hif.dx_uses_rt = 1'($urandom);
            hif.dx_rd = 5'($urandom_range(0, 3)); hif.dx_rwe = 1'($urandom);
            hif.dx_is_load = ($urandom_range(0, 2) == 0);
            hif.dx_md_start = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < NS; k++) hif.stg_rd[k*RW +: RW] = 5'($urandom_range(0, 3));
            hif.stg_rwe = 3'($urandom); hif.xm_is_store = 1'($urandom); hif.xm_rt = 5'($urandom_range(0, 3));
            settle();
            act = {hif.sel_a, hif.sel_b, hif.sel_mem_data, hif.stall_pc, hif.stall_fd, hif.stall_dx, hif.bubble_dx, hif.md_busy, hif.md_done};
            exp = {e_sel_a, e_sel_b, e_mem, e_stall, e_stall, e_stall_dx, e_stall, e_busy, e_done};
            n_cmp++;
            if (act !== exp) begin n_err++; $display("FAIL random_outputs_c%0d: got %b expected %b", i, act, exp); end
            n_cmp++;
            if (hif.stall_count !== 32'(sc)) begin n_err++; $display("FAIL random_count_c%0d: got %0d expected %0d", i, hif.stall_count, sc); end
            advance();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_md();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
